obi_error_slave: RTL and testbench



---
 rtl/obi_error_slave.sv | 121 ++++++++++++
 tb/tb_obi_error_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_error_slave.sv
// Default (error) OBI slave: grants every request, answers after a fixed latency,
// and records the first faulting access plus a saturating fault count and irq.
package obi_error_slave_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_error_slave
  import obi_error_slave_pkg::*;
#(
  parameter int unsigned RESP_LATENCY  = 1,
  parameter logic [31:0] RESP_RDATA    = 32'hBADACCE5,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  obi_req_t                 slave_req_i,
  output obi_resp_t                slave_resp_o,
  input  logic                     err_clear_i,
  output logic                     err_valid_o,
  output logic [31:0]              err_addr_o,
  output logic                     err_we_o,
  output logic [3:0]               err_be_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic                     err_irq_o
);

  logic                    gnt;
  logic                    accept;
  logic [RESP_LATENCY-1:0] pipe_valid;
  logic [RESP_LATENCY-1:0] pipe_we;
  logic                    ret_valid;
  logic                    ret_we;

  assign gnt    = slave_req_i.req & ~rst_i;
  assign accept = slave_req_i.req & gnt;

  // Fixed-latency response pipeline; the last stage is the one retiring.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_we    <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_we[0]    <= slave_req_i.we;
      for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_we[i]    <= pipe_we[i-1];
      end
    end
  end

  assign ret_valid = pipe_valid[RESP_LATENCY-1];
  assign ret_we    = pipe_we[RESP_LATENCY-1];

  always_comb begin
    slave_resp_o        = '0;
    slave_resp_o.gnt    = gnt;
    slave_resp_o.rvalid = ret_valid;
    slave_resp_o.rdata  = (ret_valid && !ret_we) ? RESP_RDATA : '0;
  end

  // A clear coinciding with an accept restarts capture from that accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_we_o    <= 1'b0;
      err_be_o    <= '0;
      err_irq_o   <= 1'b0;
    end else begin
      err_irq_o <= 1'b0;
      if (accept && (!err_valid_o || err_clear_i)) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= slave_req_i.addr;
        err_we_o    <= slave_req_i.we;
        err_be_o    <= slave_req_i.be;
        err_irq_o   <= 1'b1;
      end else if (err_clear_i) begin
        err_valid_o <= 1'b0;
        err_addr_o  <= '0;
        err_we_o    <= 1'b0;
        err_be_o    <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_o <= '0;
    end else if (err_clear_i) begin
      err_count_o <= accept ? ERR_CNT_WIDTH'(1) : '0;
    end else if (accept && (err_count_o != '1)) begin
      err_count_o <= err_count_o + ERR_CNT_WIDTH'(1);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (slave_req_i.we)
        $display("obi_error_slave: t=%0t write addr=%h wdata=%h", $time,
                 slave_req_i.addr, slave_req_i.wdata);
      else
        $display("obi_error_slave: t=%0t read addr=%h", $time, slave_req_i.addr);
    end
  end
`endif

endmodule

// File: tb/tb_obi_error_slave.sv
// Directed bench for obi_error_slave: a vector table on a latency-1 instance plus
// hand sequences for pipelining, saturation and mid-flight reset on other instances.
module tb_obi_error_slave;
  import obi_error_slave_pkg::*;

  logic     clk;
  logic     rst;
  logic     clr;
  obi_req_t req;

  obi_resp_t   resp1, resp3, resp2;
  logic        ev1, ew1, ei1, ev3, ew3, ei3, ev2, ew2, ei2;
  logic [31:0] ea1, ea3, ea2;
  logic [3:0]  eb1, eb3, eb2;
  logic [15:0] ec1, ec2;
  logic [3:0]  ec3;

  int total = 0;
  int bad   = 0;

  obi_error_slave #(.RESP_LATENCY(1), .RESP_RDATA(32'hBADACCE5), .ERR_CNT_WIDTH(16)) u1 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req), .slave_resp_o(resp1), .err_clear_i(clr),
    .err_valid_o(ev1), .err_addr_o(ea1), .err_we_o(ew1), .err_be_o(eb1),
    .err_count_o(ec1), .err_irq_o(ei1));

  obi_error_slave #(.RESP_LATENCY(3), .RESP_RDATA(32'hBADACCE5), .ERR_CNT_WIDTH(4)) u3 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req), .slave_resp_o(resp3), .err_clear_i(clr),
    .err_valid_o(ev3), .err_addr_o(ea3), .err_we_o(ew3), .err_be_o(eb3),
    .err_count_o(ec3), .err_irq_o(ei3));

  obi_error_slave #(.RESP_LATENCY(2), .RESP_RDATA(32'hBADACCE5), .ERR_CNT_WIDTH(16)) u2 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req), .slave_resp_o(resp2), .err_clear_i(clr),
    .err_valid_o(ev2), .err_addr_o(ea2), .err_we_o(ew2), .err_be_o(eb2),
    .err_count_o(ec2), .err_irq_o(ei2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, clr, rq, we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] ea;
    logic        ew;
    logic [3:0]  eb;
    logic [15:0] ec;
    logic        ei;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic c, input logic rq, input logic we,
                        input logic [3:0] be, input logic [31:0] addr);
    rst       = r;
    clr       = c;
    req.req   = rq;
    req.we    = we;
    req.be    = be;
    req.addr  = addr;
    req.wdata = addr ^ 32'h5A5A_0000;
  endtask

  // Inputs are applied a little after a rising edge; outputs sampled 1 time unit after the next.
  task automatic cyc(input logic r, input logic c, input logic rq, input logic we,
                     input logic [3:0] be, input logic [31:0] addr);
    set_in(r, c, rq, we, be, addr);
    @(posedge clk);
    #1;
  endtask

  int nrv;
  int seen;
  logic [0:5]  exp_rv;
  logic [0:5]  exp_irq;
  logic [31:0] exp_rd[6];

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);

    //        rst  clr  rq   we   be    addr          gnt  rv   rdata          ev   ea            ew   eb    ec  ei
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,4'h0,32'h0,        1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b0,4'h0,16'd0,1'b0};
    vt[1]  = '{1'b1,1'b0,1'b1,1'b0,4'hF,32'h100,      1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b0,4'h0,16'd0,1'b0};
    vt[2]  = '{1'b0,1'b0,1'b1,1'b0,4'hF,32'h2000_0000,1'b1,1'b1,32'hBADACCE5,  1'b1,32'h2000_0000,1'b0,4'hF,16'd1,1'b1};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b0,4'h0,32'h0,        1'b0,1'b0,32'h0,         1'b1,32'h2000_0000,1'b0,4'hF,16'd1,1'b0};
    vt[4]  = '{1'b0,1'b0,1'b1,1'b1,4'h3,32'h40,       1'b1,1'b1,32'h0,         1'b1,32'h2000_0000,1'b0,4'hF,16'd2,1'b0};
    vt[5]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,32'h0,        1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b0,4'h0,16'd0,1'b0};
    vt[6]  = '{1'b0,1'b0,1'b1,1'b0,4'hF,32'h8,        1'b1,1'b1,32'hBADACCE5,  1'b1,32'h8,        1'b0,4'hF,16'd1,1'b1};
    vt[7]  = '{1'b0,1'b0,1'b1,1'b1,4'h1,32'h40,       1'b1,1'b1,32'h0,         1'b1,32'h8,        1'b0,4'hF,16'd2,1'b0};
    vt[8]  = '{1'b0,1'b1,1'b1,1'b1,4'hC,32'h44,       1'b1,1'b1,32'h0,         1'b1,32'h44,       1'b1,4'hC,16'd1,1'b1};
    vt[9]  = '{1'b0,1'b0,1'b1,1'b0,4'hF,32'h50,       1'b1,1'b1,32'hBADACCE5,  1'b1,32'h44,       1'b1,4'hC,16'd2,1'b0};
    vt[10] = '{1'b0,1'b1,1'b0,1'b0,4'h0,32'h0,        1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b0,4'h0,16'd0,1'b0};

    for (int i = 0; i < 11; i++) begin
      set_in(vt[i].rst, vt[i].clr, vt[i].rq, vt[i].we, vt[i].be, vt[i].addr);
      #1;
      chk($sformatf("v%0d gnt", i), {31'b0, resp1.gnt}, {31'b0, vt[i].gnt});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rvalid", i), {31'b0, resp1.rvalid}, {31'b0, vt[i].rv});
      chk($sformatf("v%0d rdata", i), resp1.rdata, vt[i].rdata);
      chk($sformatf("v%0d err_valid", i), {31'b0, ev1}, {31'b0, vt[i].ev});
      chk($sformatf("v%0d err_addr", i), ea1, vt[i].ea);
      chk($sformatf("v%0d err_we", i), {31'b0, ew1}, {31'b0, vt[i].ew});
      chk($sformatf("v%0d err_be", i), {28'b0, eb1}, {28'b0, vt[i].eb});
      chk($sformatf("v%0d err_count", i), {16'b0, ec1}, {16'b0, vt[i].ec});
      chk($sformatf("v%0d err_irq", i), {31'b0, ei1}, {31'b0, vt[i].ei});
    end

    // Latency 3: W 0x10, R 0x14, W 0x18 back to back.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    exp_rv  = 6'b001110;
    exp_irq = 6'b100000;
    exp_rd  = '{32'h0, 32'h0, 32'h0, 32'hBADACCE5, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h10);
        1:       cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 32'h14);
        2:       cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 32'h18);
        default: cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
      endcase
      chk($sformatf("b2b%0d rvalid", i), {31'b0, resp3.rvalid}, {31'b0, exp_rv[i]});
      chk($sformatf("b2b%0d rdata", i), resp3.rdata, exp_rd[i]);
      chk($sformatf("b2b%0d irq", i), {31'b0, ei3}, {31'b0, exp_irq[i]});
    end
    chk("b2b err_addr", ea3, 32'h10);
    chk("b2b err_we", {31'b0, ew3}, 32'd1);
    chk("b2b err_be", {28'b0, eb3}, 32'hF);
    chk("b2b err_count", {28'b0, ec3}, 32'd3);

    // Clear while a read is in flight: capture clears, response still retires.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    chk("clrpipe err_valid", {31'b0, ev3}, 32'd0);
    chk("clrpipe err_count", {28'b0, ec3}, 32'd0);
    chk("clrpipe rvalid early", {31'b0, resp3.rvalid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    chk("clrpipe rvalid", {31'b0, resp3.rvalid}, 32'd1);
    chk("clrpipe rdata", resp3.rdata, 32'hBADACCE5);

    // 4-bit counter saturation over 20 accepts.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    nrv = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b0, 1'b1, k[0], 4'hF, 32'(k * 4));
      if (resp3.rvalid) nrv++;
      if (k == 5)  chk("sat count@5", {28'b0, ec3}, 32'd5);
      if (k == 15) chk("sat count@15", {28'b0, ec3}, 32'd15);
      if (k == 16) chk("sat count@16", {28'b0, ec3}, 32'd15);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
      if (resp3.rvalid) nrv++;
    end
    chk("sat count final", {28'b0, ec3}, 32'd15);
    chk("sat rvalid total", 32'(nrv), 32'd20);
    chk("sat err_addr", ea3, 32'h4);

    // Latency 2: reset one cycle after accepting a read drops the response.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h30);
    chk("rst accept irq", {31'b0, ei2}, 32'd1);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h34);
    #1;
    chk("rst gnt forced 0", {31'b0, resp2.gnt}, 32'd0);
    seen = 0;
    @(posedge clk);
    #1;
    if (resp2.rvalid) seen++;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h34);
    if (resp2.rvalid) seen++;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
      if (resp2.rvalid) seen++;
    end
    chk("rst no rvalid", 32'(seen), 32'd0);
    chk("rst rdata", resp2.rdata, 32'h0);
    chk("rst err_valid", {31'b0, ev2}, 32'd0);
    chk("rst err_addr", ea2, 32'h0);
    chk("rst err_be", {28'b0, eb2}, 32'h0);
    chk("rst err_count", {16'b0, ec2}, 32'd0);
    chk("rst err_irq", {31'b0, ei2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
